// File: rtl/lau_pkg.sv
// Shared library types: incrementer speed/area selection.
package lau_pkg;
    typedef enum logic {
        SLOW = 1'b0,
        FAST = 1'b1
    } speed_e;
endpackage

// File: rtl/IncGrayC.sv
// Gray-code incrementer: Z = gray(bin(A) + CI). Speed picks the Gray->binary structure.
module IncGrayC
    import lau_pkg::*;
#(
    parameter int     Width = 16,
    parameter speed_e Speed = FAST
) (
    input  logic [Width-1:0] A,
    input  logic             CI,
    output logic [Width-1:0] Z
);
    logic [Width-1:0] bin;
    logic [Width-1:0] sum;

    generate
        if (Speed == FAST) begin : g_fast
            // Each binary bit is an independent XOR reduction of the Gray bits above it
            always_comb begin
                for (int i = 0; i < Width; i++) bin[i] = ^(A >> i);
            end
        end else begin : g_slow
            // Ripple prefix-XOR from the MSB down
            always_comb begin
                logic acc;
                acc = 1'b0;
                for (int i = Width - 1; i >= 0; i--) begin
                    acc    = acc ^ A[i];
                    bin[i] = acc;
                end
            end
        end
    endgenerate

    assign sum = bin + {{(Width - 1){1'b0}}, CI};
    assign Z   = sum ^ (sum >> 1);
endmodule

// File: rtl/gray_rr_arbiter.sv
// Round-robin arbiter: first valid request at or after ptr, wrapping modulo NumReq.
module gray_rr_arbiter #(
    parameter int NumReq = 4,
    parameter int IdxW   = 2
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [NumReq-1:0] gnt,
    output logic [IdxW-1:0]   gnt_idx,
    output logic              gnt_any
);
    // Scan NumReq positions starting at ptr; idle grant index is 0
    always_comb begin
        int c;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            c = int'(ptr) + k;
            if (c >= NumReq) c = c - NumReq;
            if (!gnt_any && req[c]) begin
                gnt[c]  = 1'b1;
                gnt_idx = IdxW'(c);
                gnt_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gray_cnt_arbiter.sv
// Bank of Gray event counters sharing one incrementer, round-robin arbitrated,
// with a registered completion record per handshake.
module gray_cnt_arbiter
    import lau_pkg::*;
#(
    parameter int     NumReq   = 4,
    parameter int     Width    = 16,
    parameter speed_e Speed    = FAST,
    parameter bit     Saturate = 1'b0,
    localparam int    IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NumReq-1:0]       ReqValid,
    input  logic [NumReq-1:0]       ReqClr,
    output logic [NumReq-1:0]       ReqReady,
    output logic [NumReq*Width-1:0] Cnt,
    output logic                    DoneValid,
    output logic [IdxW-1:0]         DoneIdx,
    output logic [Width-1:0]        DoneCnt,
    output logic                    DoneWrap
);
    // Largest Gray code (binary 2^Width-1)
    localparam logic [Width-1:0] GMAX = {1'b1, {(Width - 1){1'b0}}};

    logic [NumReq-1:0][Width-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0]              ptr_q, ptr_d;
    logic                         done_valid_q, done_valid_d;
    logic [IdxW-1:0]              done_idx_q, done_idx_d;
    logic [Width-1:0]             done_cnt_q, done_cnt_d;
    logic                         done_wrap_q, done_wrap_d;

    logic [NumReq-1:0] gnt;
    logic [IdxW-1:0]   gnt_idx;
    logic              gnt_any;
    logic              hs;
    logic [Width-1:0]  inc_in, inc_out;

    gray_rr_arbiter #(.NumReq(NumReq), .IdxW(IdxW)) u_arb (
        .req     (ReqValid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Grants are suppressed during reset so nothing is accepted
    assign ReqReady = RST ? '0 : gnt;
    assign hs       = gnt_any & ~RST;

    // Idle grant index is 0, so the mux naturally falls back to counter 0
    assign inc_in = cnt_q[gnt_idx];

    IncGrayC #(.Width(Width), .Speed(Speed)) u_inc (
        .A  (inc_in),
        .CI (1'b1),
        .Z  (inc_out)
    );

    // Write-back, pointer advance and completion record for the granted op
    always_comb begin
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        done_valid_d = 1'b0;
        done_idx_d   = done_idx_q;
        done_cnt_d   = done_cnt_q;
        done_wrap_d  = done_wrap_q;
        if (hs) begin
            done_valid_d = 1'b1;
            done_idx_d   = gnt_idx;
            ptr_d        = (int'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + IdxW'(1);
            if (ReqClr[gnt_idx]) begin
                cnt_d[gnt_idx] = '0;
                done_wrap_d    = 1'b0;
            end else if (inc_in != GMAX) begin
                cnt_d[gnt_idx] = inc_out;
                done_wrap_d    = 1'b0;
            end else if (!Saturate) begin
                cnt_d[gnt_idx] = inc_out;
                done_wrap_d    = 1'b1;
            end else begin
                done_wrap_d    = 1'b1;
            end
            done_cnt_d = cnt_d[gnt_idx];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q        <= '0;
            ptr_q        <= '0;
            done_valid_q <= 1'b0;
            done_idx_q   <= '0;
            done_cnt_q   <= '0;
            done_wrap_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            done_valid_q <= done_valid_d;
            done_idx_q   <= done_idx_d;
            done_cnt_q   <= done_cnt_d;
            done_wrap_q  <= done_wrap_d;
        end
    end

    assign Cnt       = cnt_q;
    assign DoneValid = done_valid_q;
    assign DoneIdx   = done_idx_q;
    assign DoneCnt   = done_cnt_q;
    assign DoneWrap  = done_wrap_q;
endmodule
